// File: rtl/crossing_pkg.sv
// Shared state encoding and light-code constants for the pedestrian crossing.
package crossing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WALK  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [2:0] L_RED       = 3'b100;
  localparam logic [2:0] L_RED_AMBER = 3'b110;
  localparam logic [2:0] L_GREEN     = 3'b001;
  localparam logic [2:0] L_AMBER     = 3'b010;

  function automatic logic light_legal(input logic [2:0] l);
    return (l == L_RED) || (l == L_RED_AMBER) || (l == L_GREEN) || (l == L_AMBER);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing the WALK and CLEAR phases; stops at zero.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             en,
  output logic [CNT_W-1:0] count_next,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The next value is exported so the owner can register it alongside its state.
  assign count_next = count_d;
  assign zero       = (count_q == '0);

endmodule

// File: rtl/pedestrian_crossing.sv
// Pedestrian crossing controller slaved to the traffic-light sequencer.
// Build option FLASH_CLEAR_EN: flashing walk lamp during the clearance phase.
module pedestrian_crossing
  import crossing_pkg::*;
#(
  parameter int WALK_CYCLES  = 8,
  parameter int CLEAR_CYCLES = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             button,
  output logic             walk,
  output logic             dont_walk,
  output logic             wait_lamp,
  output logic             hold_red,
  output logic [CNT_W-1:0] walk_count,
  output logic             fault
);

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

  state_t           state_q, state_d;
  logic             walk_q, walk_d;
  logic             dont_walk_q, dont_walk_d;
  logic             wait_lamp_q, wait_lamp_d;
  logic             hold_red_q, hold_red_d;
  logic [CNT_W-1:0] walk_count_q, walk_count_d;
  logic             fault_q, fault_d;

  logic [2:0]       light;
  logic             pure_red;
  logic             abort;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_next;
  logic             tmr_zero;

  assign light    = {red, amber, green};
  assign pure_red = (light == L_RED);
  assign abort    = ((state_q == ST_WALK) || (state_q == ST_CLEAR)) && !pure_red;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .value      (tmr_value),
    .en         (tmr_en),
    .count_next (tmr_next),
    .zero       (tmr_zero)
  );

  // Abort is tested before counter expiry so a lost red always wins.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_IDLE: if (button) state_d = ST_WAIT;
      ST_WAIT: begin
        if (pure_red) begin
          state_d   = ST_WALK;
          tmr_load  = 1'b1;
          tmr_value = WALK_LOAD;
        end
      end
      ST_WALK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d   = ST_CLEAR;
          tmr_load  = 1'b1;
          tmr_value = CLEAR_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (abort || tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lamps are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    walk_d       = 1'b0;
    dont_walk_d  = 1'b1;
    wait_lamp_d  = 1'b0;
    hold_red_d   = 1'b0;
    walk_count_d = '0;
    fault_d      = fault_q | !light_legal(light) | abort;
    case (state_d)
      ST_WAIT: begin
        wait_lamp_d = 1'b1;
        hold_red_d  = 1'b1;
      end
      ST_WALK: begin
        walk_d       = 1'b1;
        dont_walk_d  = 1'b0;
        hold_red_d   = 1'b1;
        walk_count_d = tmr_next;
      end
      ST_CLEAR: begin
        hold_red_d   = 1'b1;
        walk_count_d = tmr_next;
`ifdef FLASH_CLEAR_EN
        dont_walk_d  = 1'b0;
        walk_d       = (state_q == ST_CLEAR) ? !walk_q : 1'b0;
`else
        dont_walk_d  = 1'b1;
        walk_d       = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      walk_q       <= 1'b0;
      dont_walk_q  <= 1'b1;
      wait_lamp_q  <= 1'b0;
      hold_red_q   <= 1'b0;
      walk_count_q <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      walk_q       <= walk_d;
      dont_walk_q  <= dont_walk_d;
      wait_lamp_q  <= wait_lamp_d;
      hold_red_q   <= hold_red_d;
      walk_count_q <= walk_count_d;
      fault_q      <= fault_d;
    end
  end

  assign walk       = walk_q;
  assign dont_walk  = dont_walk_q;
  assign wait_lamp  = wait_lamp_q;
  assign hold_red   = hold_red_q;
  assign walk_count = walk_count_q;
  assign fault      = fault_q;

endmodule
